latch_reader: RTL

LATCH_READER -- requirements
Module: latch_reader

---
 rtl/latch_reader.sv | 83 ++++++++
 1 files changed

// File: rtl/latch_reader.sv
// Change-detecting latch bus sampler: every new value seen on data_in (while
// enabled) is queued into a small show-ahead FIFO with sticky overflow flag.
module latch_reader #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [width-1:0]         data_in,
  input  logic                     en,
  input  logic                     ready,
  input  logic                     clr_ovf,
  output logic [width-1:0]         data_out,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(depth):0]   count,
  output logic                     ovf
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] prev_q, prev_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [width-1:0] mem_q [depth];

  logic push, pop, accept, drop;

  assign valid  = (count_q != '0);
  assign full   = (count_q == CW'(depth));
  assign count  = count_q;
  assign ovf    = ovf_q;

  assign push   = en && (data_in != prev_q);
  assign pop    = valid && ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // only dropped when nothing leaves.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    prev_d   = en ? data_in : prev_q;
    wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Set has priority over clear.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; stale entries stay hidden because count gates valid.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = valid ? mem_q[rd_ptr_q] : '0;

endmodule
